count_history_display: RTL and testbench
========================================

# count_history_display

Downstream display stage for the 0–9 decade counter output. It watches the 4-bit BCD count and records each new value into a 4-deep history, newest value in digit 0. It time-multiplexes that history onto a 4-digit common-anode seven-segment display. Digits that have not yet been filled are blanked, and out-of-range input values are flagged.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (1 kHz/digit at 50 MHz); must be ≥2.
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  reset, asynchronous assert, active-low.
- COUNT  in  4  BCD value from the upstream counter; valid range 0–9, 10–15 treated as invalid.
- CLR  in  1  synchronous clear of history and error flag, active-high.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- AN  out  4  digit enables, active-low, registered, one-hot-low when active.
- ERR  out  1  sticky flag: an invalid COUNT value (>9) was captured.

## Operation
- State elements:
  - prev (4b)
  - primed (1b)
  - hist[0..3] (4b each)
  - fill (0–4, 3b)
  - err (1b)
  - slot (2b)
  - refresh prescaler
- Capture condition:
  - capture = !primed, or (COUNT != prev).
  - On capture: prev←COUNT, primed←1, hist[0]←COUNT, hist[i]←hist[i-1] for i=1..3, fill←min(fill+1,4).
  - If COUNT>9 on capture: err←1.
- CLR has priority over capture in the same cycle: fill←0, primed←0, err←0. hist contents are don't-care. The first capture occurs the cycle after CLR deasserts.
- Scan sequence:
  - The prescaler pulses tick for one cycle every REFRESH_DIV cycles.
  - On tick, slot advances 0→1→2→3→0 (wraps).
  - The scan runs continuously and is unaffected by CLR or capture.
- Output decode, per slot:
  - AN = ~(4'b0001 << slot).
  - If slot ≥ fill: SEG = 7'b1111111 (blank).
  - Else if hist[slot] ≤ 9: SEG = standard code.
  - Else: SEG = 7'b0111111 (dash, g only).
- Digit codes, 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
- Reset values: SEG=7'b1111111, AN=4'b1111, ERR=0, fill=0, primed=0, prev=0, slot=0, prescaler=0.
- Capture latency:
  - A COUNT change sampled at edge n updates hist/fill/err at edge n.
  - SEG/AN reflect it at edge n+1, only if that digit is the current slot.
- First capture occurs at the first edge after RSTn deasserts. fill=1 thereafter, so digit 0 shows the current COUNT.
- Slot period is exactly REFRESH_DIV cycles. Full frame is 4·REFRESH_DIV cycles.
- AN changes one cycle after tick, in the same cycle as SEG. No cycle ever has two AN bits low.
- fill saturates at 4; on further captures the oldest digit (hist[3]) is discarded.
- Repeated identical COUNT values produce no capture. An upstream wrap 9→0 is a change and is captured.
- RSTn asserted mid-frame forces all reset values immediately, without waiting for a clock edge.

## Structure
- Package count_display_pkg:
  - SEG_CODE[0:9] constant array
  - SEG_BLANK = 7'b1111111
  - SEG_DASH = 7'b0111111
  - DIGITS = 4
- Sub-module bcd_to_seg7 (combinational: 4b value + blank → 7b SEG, active-low). It is instantiated once, on the slot-selected digit.
- The prescaler is an instance of the team's existing parameterizable `counter`:
  - modulus = REFRESH_DIV, ENABLE = 1.
  - Its TC is the one-cycle tick.
  - Its COUNT output is left unconnected.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset release with COUNT=0 held:
  - During reset: SEG=1111111, AN=1111.
  - After the first tick, AN cycles 1110→1101→1011→0111 every 4 cycles.
  - SEG=1000000 only while AN=1110; blank otherwise.
- COUNT sequence 3,7,9 (each held 10 cycles):
  - Result: hist = {9,7,3}, fill=4 (includes initial 0).
  - Slots 0–3 show 0010000, 1111000, 0110000, 1000000.
- COUNT held at 5 for 100 cycles after one capture:
  - fill and hist unchanged.
  - Exactly one capture occurred.
- COUNT=12 for 2 cycles, then back to 4:
  - ERR=1 and stays 1.
  - Digit 1 shows 0111111 (dash); digit 0 shows 0011001.
- CLR pulsed while COUNT changes 2→6 in the same cycle:
  - After CLR, all digits are blank and ERR=0.
  - On the next cycle, 6 is captured: fill=1, digit 0 shows 0000010.
- RSTn asserted asynchronously mid-slot:
  - SEG/AN go to all-ones without a clock edge.
  - The scan restarts at slot 0 after release.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared constants for the count history display.
//   SEG_CODE  : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   SEG_BLANK : all segments off
//   SEG_DASH  : only segment g lit, shown for out-of-range history values
//   DIGITS    : number of display digits and history depth
package count_display_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   value_i : 4-bit value; 10-15 decode to a dash
//   blank_i : force all segments off
//   seg_o   : segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import count_display_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: assigning a default first means every path drives seg_o,
        // so no latch is inferred.
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            if (value_i <= 4'd9) seg_o = SEG_CODE[value_i];
            else                 seg_o = SEG_DASH;
        end
    end

endmodule

// File: rtl/counter.sv
// Free-running modulo-N counter with a terminal-count strobe.
//   clk, rst_n : clock, async active-low reset
//   en_i       : count enable
//   count_o    : current count, 0 .. MODULUS-1
//   tc_o       : high for the one cycle in which count_o == MODULUS-1
module counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic             at_top;

    assign at_top  = (count_q == WIDTH'(MODULUS - 1));
    assign tc_o    = en_i && at_top;
    assign count_o = count_q;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= at_top ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/count_history_display.sv
// Records each new BCD value from an upstream decade counter into a
// 4-deep history (newest in digit 0) and scans it onto a 4-digit
// common-anode seven-segment display.
//   CLK   : system clock, rising edge
//   RSTn  : async active-low reset
//   COUNT : BCD input; values above 9 are flagged as errors
//   CLR   : sync clear of history fill and error flag
//   SEG   : registered segments {g,f,e,d,c,b,a}, active-low
//   AN    : registered digit enables, active-low, one-hot-low
//   ERR   : sticky flag for a captured value above 9
module count_history_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] COUNT,
    input  logic       CLR,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       ERR
);

    logic [3:0] prev_q;
    logic       primed_q;
    logic [3:0] hist_q [DIGITS];
    logic [2:0] fill_q;
    logic       err_q;
    logic [1:0] slot_q, slot_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       tick;
    logic       capture;
    logic       blank;

    counter #(
        .MODULUS (REFRESH_DIV)
    ) u_prescaler (
        .clk     (CLK),
        .rst_n   (RSTn),
        .en_i    (1'b1),
        .count_o (),
        .tc_o    (tick)
    );

    assign capture = !primed_q || (COUNT != prev_q);

    // Outputs are decoded from the next slot so AN and SEG move together
    // on the edge that advances the slot.
    assign slot_d = tick ? slot_q + 2'd1 : slot_q;
    assign blank  = ({1'b0, slot_d} >= fill_q);
    assign an_d   = ~(4'b0001 << slot_d);

    bcd_to_seg7 u_decode (
        .value_i (hist_q[slot_d]),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            fill_q   <= '0;
            err_q    <= 1'b0;
            slot_q   <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= 4'b1111;
        end else begin
            slot_q <= slot_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            if (CLR) begin
                fill_q   <= '0;
                primed_q <= 1'b0;
                err_q    <= 1'b0;
            end else if (capture) begin
                prev_q   <= COUNT;
                primed_q <= 1'b1;
                if (fill_q != 3'(DIGITS)) fill_q <= fill_q + 3'd1;
                if (COUNT > 4'd9)         err_q  <= 1'b1;
            end
        end
    end

    // NOTE: the history is deliberately left without reset; fill_q blanks
    // any digit that has not been written since reset or clear.
    always_ff @(posedge CLK) begin
        if (!CLR && capture) begin
            hist_q[0] <= COUNT;
            for (int i = 1; i < DIGITS; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_count_history_display.sv
// Directed bench for count_history_display with REFRESH_DIV=4.
module tb_count_history_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] count;
    logic       clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    count_history_display #(
        .REFRESH_DIV (4)
    ) dut (
        .CLK   (clk),
        .RSTn  (rst_n),
        .COUNT (count),
        .CLR   (clr),
        .SEG   (seg),
        .AN    (an),
        .ERR   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the given slot is active, then check its segments.
    task automatic show_slot(input int slot, input logic [6:0] exp_seg, input string tag);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << slot);
        for (int i = 0; i < 40 && an !== exp_an; i++) @(negedge clk);
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        rst_n = 1'b0;
        count = 4'd0;
        clr   = 1'b0;

        // Reset state
        cycles(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'hF);
        check("rst_err", 32'(err), 32'h0);

        // Release with COUNT=0 held; scan cycles every 4 clocks
        rst_n = 1'b1;
        cycles(1);
        check("e1_an",  32'(an),  32'hE);
        check("e1_seg", 32'(seg), 32'h7F);
        cycles(1);
        check("e2_seg", 32'(seg), 32'h40);
        cycles(1);
        check("e3_an",  32'(an),  32'hE);
        cycles(1);
        check("e4_an",  32'(an),  32'hD);
        check("e4_seg", 32'(seg), 32'h7F);
        cycles(4);
        check("e8_an",  32'(an),  32'hB);
        cycles(4);
        check("e12_an",  32'(an),  32'h7);
        check("e12_seg", 32'(seg), 32'h7F);
        cycles(4);
        check("e16_an",  32'(an),  32'hE);
        check("e16_seg", 32'(seg), 32'h40);

        // Sequence 3,7,9 -> history {9,7,3,0}
        count = 4'd3; cycles(10);
        count = 4'd7; cycles(10);
        count = 4'd9; cycles(10);
        show_slot(0, 7'b0010000, "seq_d0");
        show_slot(1, 7'b1111000, "seq_d1");
        show_slot(2, 7'b0110000, "seq_d2");
        show_slot(3, 7'b1000000, "seq_d3");

        // Held value captured exactly once -> {5,9,7,3}
        count = 4'd5; cycles(100);
        show_slot(0, 7'b0010010, "hold_d0");
        show_slot(1, 7'b0010000, "hold_d1");
        show_slot(2, 7'b1111000, "hold_d2");
        show_slot(3, 7'b0110000, "hold_d3");

        // Invalid value 12 -> sticky ERR, dash in history {4,12,5,9}
        check("pre_err", 32'(err), 32'h0);
        count = 4'd12; cycles(1);
        check("err_set", 32'(err), 32'h1);
        cycles(1);
        count = 4'd4; cycles(30);
        check("err_sticky", 32'(err), 32'h1);
        show_slot(0, 7'b0011001, "err_d0");
        show_slot(1, 7'b0111111, "err_d1");
        show_slot(2, 7'b0010010, "err_d2");

        // CLR coincident with COUNT 2->6
        count = 4'd2; cycles(5);
        clr = 1'b1; count = 4'd6;
        cycles(1);
        clr = 1'b0;
        check("clr_err", 32'(err), 32'h0);
        cycles(1);
        check("clr_blank", 32'(seg), 32'h7F);
        show_slot(0, 7'b0000010, "clr_d0");
        show_slot(1, 7'b1111111, "clr_d1");
        show_slot(2, 7'b1111111, "clr_d2");
        show_slot(3, 7'b1111111, "clr_d3");
        check("clr_err2", 32'(err), 32'h0);

        // Async reset mid-slot
        show_slot(1, 7'b1111111, "pre_arst");
        cycles(1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an",  32'(an),  32'hF);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        check("rel_an", 32'(an), 32'hE);
        cycles(1);
        check("rel_seg", 32'(seg), 32'h02);
        cycles(2);
        check("rel_an4", 32'(an), 32'hD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
